// File: rtl/img_sram_responder.sv
// Single-image 8-bit grayscale buffer: serves random (row, col) accesses while idle,
// and streams the image in (load) or out (dump) in raster order on a host port.
module img_sram_responder #(
    parameter int MAX_ROWS = 64,
    parameter int MAX_COLS = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sram_write_en,
    input  logic       sram_sense_en,
    input  logic [7:0] sram_row,
    input  logic [7:0] sram_col,
    input  logic [7:0] sram_din,
    output logic [7:0] sram_dout,
    input  logic [7:0] nrows,
    input  logic [7:0] ncols,
    input  logic       load_start,
    input  logic       dump_start,
    input  logic       host_valid,
    input  logic [7:0] host_data,
    output logic       host_ready,
    output logic       dump_valid,
    output logic [7:0] dump_data,
    input  logic       dump_ready,
    output logic       busy,
    output logic       done
);

    localparam int DEPTH = MAX_ROWS * MAX_COLS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2
    } state_e;

    function automatic logic [AW-1:0] flat_addr(input logic [7:0] row, input logic [7:0] col);
        flat_addr = AW'(row) * AW'(MAX_COLS) + AW'(col);
    endfunction

    function automatic logic [7:0] clamp_dim(input logic [7:0] v, input int lim);
        if ({1'b0, v} > 9'(lim)) begin
            clamp_dim = 8'(lim);
        end else begin
            clamp_dim = v;
        end
    endfunction

    state_e     state_q, state_d;
    logic [7:0] nr_q, nr_d, nc_q, nc_d;
    logic [7:0] r_q, r_d, c_q, c_d;
    logic       busy_q, busy_d;
    logic       host_ready_q, host_ready_d;
    logic       done_q, done_d;
    logic       dump_valid_q, dump_valid_d;
    logic [7:0] dump_data_q, dump_data_d;
    logic       pf_valid_q, pf_valid_d;
    logic [7:0] pf_data_q, pf_data_d;
    logic       rd_pend_q, rd_pend_d;
    logic       issue_done_q, issue_done_d;
    logic       dout_sel_q, dout_sel_d;

    logic [7:0]    mem_q [0:DEPTH-1];
    logic [7:0]    mem_rd_q;
    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [7:0]    mem_wdata_s;
    logic [AW-1:0] mem_raddr_s;

    logic       acc_ok_s;
    logic [7:0] nr_clamp_s, nc_clamp_s;
    logic       dims_zero_s;
    logic       col_wrap_s, last_s;
    logic [7:0] r_adv_s, c_adv_s;
    logic       pop_s;
    logic [1:0] occ_s;
    logic       issue_s;
    logic       sense_unused_s;

    // Reads are never gated by sense_en; the input exists only for protocol completeness.
    assign sense_unused_s = sram_sense_en;

    assign acc_ok_s    = ({1'b0, sram_row} < 9'(MAX_ROWS)) && ({1'b0, sram_col} < 9'(MAX_COLS));
    assign nr_clamp_s  = clamp_dim(nrows, MAX_ROWS);
    assign nc_clamp_s  = clamp_dim(ncols, MAX_COLS);
    assign dims_zero_s = (nr_clamp_s == 8'd0) || (nc_clamp_s == 8'd0);

    assign col_wrap_s = (c_q == (nc_q - 8'd1));
    assign last_s     = col_wrap_s && (r_q == (nr_q - 8'd1));
    assign c_adv_s    = col_wrap_s ? 8'd0 : (c_q + 8'd1);
    assign r_adv_s    = col_wrap_s ? (r_q + 8'd1) : r_q;

    // Output slot + prefetch slot hold at most two bytes, counting the read in flight.
    assign pop_s   = dump_valid_q && dump_ready;
    assign occ_s   = {1'b0, dump_valid_q} + {1'b0, pf_valid_q} + {1'b0, rd_pend_q};
    assign issue_s = (state_q == ST_DUMP) && !issue_done_q && ((occ_s - {1'b0, pop_s}) < 2'd2);

    // Next-state, memory port steering and dump pipeline control.
    always_comb begin
        state_d      = state_q;
        nr_d         = nr_q;
        nc_d         = nc_q;
        r_d          = r_q;
        c_d          = c_q;
        busy_d       = busy_q;
        host_ready_d = host_ready_q;
        done_d       = 1'b0;
        dump_valid_d = dump_valid_q;
        dump_data_d  = dump_data_q;
        pf_valid_d   = pf_valid_q;
        pf_data_d    = pf_data_q;
        rd_pend_d    = 1'b0;
        issue_done_d = issue_done_q;
        dout_sel_d   = 1'b0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = {AW{1'b0}};
        mem_wdata_s  = 8'h00;
        mem_raddr_s  = {AW{1'b0}};

        case (state_q)
            ST_IDLE: begin
                dout_sel_d = acc_ok_s;
                if (acc_ok_s) begin
                    mem_raddr_s = flat_addr(sram_row, sram_col);
                end else begin
                    mem_raddr_s = {AW{1'b0}};
                end
                if (sram_write_en && acc_ok_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = flat_addr(sram_row, sram_col);
                    mem_wdata_s = sram_din;
                end else begin
                    mem_we_s = 1'b0;
                end
                if (load_start || dump_start) begin
                    nr_d         = nr_clamp_s;
                    nc_d         = nc_clamp_s;
                    r_d          = 8'd0;
                    c_d          = 8'd0;
                    issue_done_d = 1'b0;
                    pf_valid_d   = 1'b0;
                    dump_valid_d = 1'b0;
                    if (dims_zero_s) begin
                        done_d = 1'b1;
                    end else if (load_start) begin
                        state_d      = ST_LOAD;
                        busy_d       = 1'b1;
                        host_ready_d = 1'b1;
                        dout_sel_d   = 1'b0;
                    end else begin
                        // First pixel is fetched in the start cycle so data is ready one cycle earlier.
                        state_d      = ST_DUMP;
                        busy_d       = 1'b1;
                        dout_sel_d   = 1'b0;
                        mem_raddr_s  = {AW{1'b0}};
                        rd_pend_d    = 1'b1;
                        issue_done_d = (nr_clamp_s == 8'd1) && (nc_clamp_s == 8'd1);
                        if (nc_clamp_s == 8'd1) begin
                            r_d = 8'd1;
                            c_d = 8'd0;
                        end else begin
                            r_d = 8'd0;
                            c_d = 8'd1;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                if (host_valid && host_ready_q) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = flat_addr(r_q, c_q);
                    mem_wdata_s = host_data;
                    r_d         = r_adv_s;
                    c_d         = c_adv_s;
                    if (last_s) begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        host_ready_d = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_DUMP: begin
                rd_pend_d = issue_s;
                if (issue_s) begin
                    mem_raddr_s  = flat_addr(r_q, c_q);
                    r_d          = r_adv_s;
                    c_d          = c_adv_s;
                    issue_done_d = last_s;
                end else begin
                    mem_raddr_s = {AW{1'b0}};
                end
                if (!dump_valid_q || pop_s) begin
                    if (pf_valid_q) begin
                        dump_valid_d = 1'b1;
                        dump_data_d  = pf_data_q;
                        pf_valid_d   = rd_pend_q;
                        pf_data_d    = rd_pend_q ? mem_rd_q : pf_data_q;
                    end else if (rd_pend_q) begin
                        dump_valid_d = 1'b1;
                        dump_data_d  = mem_rd_q;
                    end else begin
                        dump_valid_d = 1'b0;
                    end
                end else if (rd_pend_q) begin
                    pf_valid_d = 1'b1;
                    pf_data_d  = mem_rd_q;
                end else begin
                    pf_valid_d = pf_valid_q;
                end
                if (pop_s && issue_done_q && !pf_valid_q && !rd_pend_q) begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    dump_valid_d = 1'b0;
                    rd_pend_d    = 1'b0;
                end else begin
                    state_d = ST_DUMP;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                host_ready_d = 1'b0;
                dump_valid_d = 1'b0;
                pf_valid_d   = 1'b0;
            end
        endcase
    end

    // Control and output registers; the image array below deliberately has no reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            nr_q         <= 8'd0;
            nc_q         <= 8'd0;
            r_q          <= 8'd0;
            c_q          <= 8'd0;
            busy_q       <= 1'b0;
            host_ready_q <= 1'b0;
            done_q       <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= 8'h00;
            pf_valid_q   <= 1'b0;
            pf_data_q    <= 8'h00;
            rd_pend_q    <= 1'b0;
            issue_done_q <= 1'b0;
            dout_sel_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            nr_q         <= nr_d;
            nc_q         <= nc_d;
            r_q          <= r_d;
            c_q          <= c_d;
            busy_q       <= busy_d;
            host_ready_q <= host_ready_d;
            done_q       <= done_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            pf_valid_q   <= pf_valid_d;
            pf_data_q    <= pf_data_d;
            rd_pend_q    <= rd_pend_d;
            issue_done_q <= issue_done_d;
            dout_sel_q   <= dout_sel_d;
        end
    end

    // Single-write, single-read array; a same-address read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
        mem_rd_q <= mem_q[mem_raddr_s];
    end

    assign sram_dout  = dout_sel_q ? mem_rd_q : 8'h00;
    assign host_ready = host_ready_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_img_sram_responder.sv
// Scoreboard bench for img_sram_responder: stimulus pushes expected bytes, a monitor
// pops and compares on every access-port read and dump handshake.
module tb_img_sram_responder;

    localparam int MR = 64;
    localparam int MC = 64;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sram_write_en = 1'b0, sram_sense_en = 1'b0;
    logic [7:0] sram_row = 8'd0, sram_col = 8'd0, sram_din = 8'd0;
    logic [7:0] sram_dout;
    logic [7:0] nrows = 8'd0, ncols = 8'd0;
    logic       load_start = 1'b0, dump_start = 1'b0;
    logic       host_valid = 1'b0;
    logic [7:0] host_data = 8'd0;
    logic       host_ready, dump_valid, busy, done;
    logic [7:0] dump_data;
    logic       dump_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    logic [7:0] rd_q[$];
    logic [7:0] dump_q[$];
    logic       rd_req = 1'b0;
    logic       rd_pend_tb = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] held = 8'd0;
    logic [7:0] mon_e;

    img_sram_responder #(.MAX_ROWS(MR), .MAX_COLS(MC)) dut (
        .clk(clk), .rstn(rstn),
        .sram_write_en(sram_write_en), .sram_sense_en(sram_sense_en),
        .sram_row(sram_row), .sram_col(sram_col), .sram_din(sram_din), .sram_dout(sram_dout),
        .nrows(nrows), .ncols(ncols), .load_start(load_start), .dump_start(dump_start),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: read data one cycle after each tagged read, dump bytes on each handshake.
    initial forever begin
        @(posedge clk);
        rd_pend_tb = rd_req;
        @(negedge clk);
        if (rd_pend_tb) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got %0h expected none", sram_dout);
            end else begin
                mon_e = rd_q.pop_front();
                chk("sram_dout", {24'd0, sram_dout}, {24'd0, mon_e});
            end
        end
        if (done) done_cnt++;
        if (stall_prev) chk("dump_hold", {23'd0, dump_valid, dump_data}, {23'd0, 1'b1, held});
        if (dump_valid && dump_ready) begin
            hs_cnt++;
            if (dump_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL dump_unexpected: got %0h expected none", dump_data);
            end else begin
                mon_e = dump_q.pop_front();
                chk("dump_data", {24'd0, dump_data}, {24'd0, mon_e});
            end
        end
        stall_prev = dump_valid && !dump_ready;
        held = dump_data;
    end

    task automatic sram_read(input logic [7:0] r, input logic [7:0] c, input logic [7:0] e);
        sram_row = r; sram_col = c; rd_req = 1'b1;
        rd_q.push_back(e);
        tick;
        rd_req = 1'b0;
    endtask

    task automatic sram_write(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
        sram_row = r; sram_col = c; sram_din = d; sram_write_en = 1'b1;
        tick;
        sram_write_en = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] nr, input logic [7:0] nc, input logic alt, input int abort_at);
        int d0, rc, n;
        d0 = done_cnt; rc = 0; n = int'(nr) * int'(nc);
        nrows = nr; ncols = nc; load_start = 1'b1;
        tick;
        load_start = 1'b0;
        chk("load_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) break;
            host_valid = 1'b1;
            host_data = alt ? 8'(8'h80 + i) : 8'((i / int'(nc)) * 16 + (i % int'(nc)));
            if (host_ready) rc++;
            tick;
        end
        host_valid = 1'b0;
        if (abort_at >= 0) begin
            rstn = 1'b0;
            #2;
            chk("abort_busy", busy, 0);
            chk("abort_host_ready", host_ready, 0);
            chk("abort_done", done, 0);
            chk("abort_dump_valid", dump_valid, 0);
            chk("abort_dump_data", dump_data, 0);
            chk("abort_dout", sram_dout, 0);
            tick;
            rstn = 1'b1;
            tick;
            chk("abort_no_done", done_cnt - d0, 0);
        end else begin
            chk("load_done", done, 1);
            chk("load_done_busy", busy, 0);
            chk("load_done_ready", host_ready, 0);
            chk("load_ready_cycles", rc, n);
            tick;
            chk("load_done_pulse", done, 0);
            chk("load_done_count", done_cnt - d0, 1);
        end
    endtask

    task automatic do_dump(input logic [7:0] nr, input logic [7:0] nc);
        int h0, d0;
        logic got;
        for (int r = 0; r < int'(nr); r++)
            for (int c = 0; c < int'(nc); c++)
                dump_q.push_back(8'(r * 16 + c));
        h0 = hs_cnt; d0 = done_cnt; got = 1'b0;
        nrows = nr; ncols = nc; dump_start = 1'b1; dump_ready = 1'b0;
        tick;
        dump_start = 1'b0;
        chk("dump_busy", busy, 1);
        chk("dump_not_yet_valid", dump_valid, 0);
        for (int k = 0; k < 200 && !got; k++) begin
            dump_ready = (k % 2 == 1);
            tick;
            if (k == 0) chk("dump_first_valid", dump_valid, 1);
            got = done;
        end
        dump_ready = 1'b0;
        chk("dump_done_seen", got, 1);
        chk("dump_done_busy", busy, 0);
        tick;
        chk("dump_handshakes", hs_cnt - h0, int'(nr) * int'(nc));
        chk("dump_queue_empty", dump_q.size(), 0);
        chk("dump_done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick; tick;
        chk("rst_dout", sram_dout, 0);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_data", dump_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rstn = 1'b1;
        tick;

        do_load(8'd4, 8'd6, 1'b0, -1);
        sram_read(8'd2, 8'd5, 8'h25);
        sram_read(8'd0, 8'd0, 8'h00);
        sram_read(8'd3, 8'd4, 8'h34);
        tick;

        do_dump(8'd4, 8'd6);

        sram_write(8'd3, 8'd3, 8'hAA);
        sram_read(8'd3, 8'd3, 8'hAA);
        sram_row = 8'd1; sram_col = 8'd1; sram_din = 8'h55;
        sram_write_en = 1'b1; rd_req = 1'b1; rd_q.push_back(8'h11);
        tick;
        sram_write_en = 1'b0; rd_req = 1'b0;
        sram_read(8'd1, 8'd1, 8'h55);

        sram_write(8'd0, 8'd0, 8'h3C);
        sram_read(8'(MR), 8'd0, 8'h00);
        sram_write(8'd0, 8'(MC), 8'h99);
        sram_read(8'd1, 8'd0, 8'h10);
        sram_read(8'd0, 8'd0, 8'h3C);
        tick;

        nrows = 8'd1; ncols = 8'd2; load_start = 1'b1; dump_start = 1'b1;
        tick;
        load_start = 1'b0; dump_start = 1'b0;
        chk("prio_load_ready", host_ready, 1);
        host_valid = 1'b1; host_data = 8'h70; dump_start = 1'b1;
        tick;
        dump_start = 1'b0; host_data = 8'h71;
        chk("ign_dump_busy", busy, 1);
        chk("ign_dump_ready", host_ready, 1);
        tick;
        host_valid = 1'b0;
        chk("prio_done", done, 1);
        chk("prio_no_dump", dump_valid, 0);
        tick;
        chk("ign_dump_idle", busy, 0);
        sram_read(8'd0, 8'd0, 8'h70);
        sram_read(8'd0, 8'd1, 8'h71);
        tick;

        nrows = 8'd0; ncols = 8'd6; load_start = 1'b1;
        tick;
        load_start = 1'b0;
        chk("zero_load_done", done, 1);
        chk("zero_load_busy", busy, 0);
        chk("zero_load_ready", host_ready, 0);
        tick;
        chk("zero_load_pulse", done, 0);
        nrows = 8'd3; ncols = 8'd0; dump_start = 1'b1;
        tick;
        dump_start = 1'b0;
        chk("zero_dump_done", done, 1);
        chk("zero_dump_valid", dump_valid, 0);
        tick;
        chk("zero_dump_idle", busy, 0);

        do_load(8'd4, 8'd6, 1'b1, 10);
        for (int i = 0; i <= 10; i++) begin
            sram_read(8'(i / 6), 8'(i % 6), (i < 10) ? 8'(8'h80 + i) : 8'h14);
        end
        tick; tick;
        chk("rd_queue_empty", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
